// File: rtl/shift_pkg.sv
// Shared definitions for the parameterised shift engine.
package shift_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts completed shifts and flags the edge that performs the final shift.
module shift_bit_counter
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_last
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] count;

   // Count shifts; a new load clears it and it saturates at WIDTH so it can never run past the word length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CW'(WIDTH))) begin
         count <= count + CW'(1);
      end
   end

   assign at_last = inc && (count == CW'(WIDTH - 1));

endmodule

// File: rtl/param_shift_engine.sv
// Loadable shift register that streams a word out serially, one bit per enabled clock.
module param_shift_engine
   import shift_pkg::*;
#(
   parameter int   WIDTH = DEFAULT_WIDTH,
   parameter logic FILL  = 1'b0
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_data,
   input  logic             dir,
   input  logic             rot,
   input  logic             ser_sel,
   input  logic             ser_in,
   input  logic             en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] par_out
);

   state_t           state;
   logic [WIDTH-1:0] shReg;
   logic [WIDTH-1:0] nextReg;
   logic             dirL;
   logic             rotL;
   logic             selL;
   logic             outBit;
   logic             inBit;
   logic             cntClr;
   logic             cntInc;
   logic             atLast;

   // Work out the bit leaving the register, the bit refilling it, and the shifted word.
   always_comb begin
      outBit  = dirL ? shReg[WIDTH-1] : shReg[0];
      inBit   = rotL ? outBit : (selL ? ser_in : FILL);
      nextReg = dirL ? {shReg[WIDTH-2:0], inBit} : {inBit, shReg[WIDTH-1:1]};
   end

   assign cntClr = (state == IDLE) && start;
   assign cntInc = (state == SHIFT) && en;

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .clr     (cntClr),
      .inc     (cntInc),
      .at_last (atLast)
   );

   // Control FSM: load and latch mode on start, shift while enabled, publish the word for one DONE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shReg     <= '0;
         dirL      <= 1'b0;
         rotL      <= 1'b0;
         selL      <= 1'b0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         par_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               ser_valid <= 1'b0;
               if (start) begin
                  shReg <= load_data;
                  dirL  <= dir;
                  rotL  <= rot;
                  selL  <= ser_sel;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (en) begin
                  shReg     <= nextReg;
                  ser_out   <= outBit;
                  ser_valid <= 1'b1;
                  if (atLast) begin
                     par_out <= nextReg;
                     state   <= DONE;
                  end
               end else begin
                  ser_valid <= 1'b0;
               end
            end
            DONE: begin
               ser_valid <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               ser_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
